// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave memory with programmable wait states and a two-cycle ERROR response.
// Optional AHB_SLV_RAND_WAIT_EN: per-beat random 0..WAIT_STATES waits from a 16-bit LFSR.
module ahb_slave_mem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [OFF+AW-1:0] a_q;
  logic              w_q;
  logic [2:0]        s_q;
  logic [3:0]        cnt, cnt_nxt, wt;
  logic              accept, err, wr_en;
  logic [OFF-1:0]    amask;
  logic [NB-1:0]     be;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              unused;
  assign unused = ^{HBURST, HTRANS[0]};
`ifdef AHB_SLV_RAND_WAIT_EN
  logic [15:0] lfsr;
  always_ff @(posedge HCLK)
    if (HRESET) lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign wt = 4'(lfsr % 16'(WAIT_STATES + 1));
`else
  assign wt = 4'(WAIT_STATES);
`endif
  assign accept    = HSEL && HREADY && HTRANS[1] && (state inside {IDLE, DATA, ERR2});
  assign wr_en     = state == DATA && w_q && !HRESET;
  assign HREADYOUT = !(state == WAIT || state == ERR1);
  assign HRESP     = {1'b0, state == ERR1 || state == ERR2};
  always_comb begin
    for (int i = 0; i < OFF; i++) amask[i] = i < int'(HSIZE);
    err = (HADDR >> OFF) >= DEPTH_A || int'(HSIZE) > OFF || |(HADDR[OFF-1:0] & amask);
    for (int i = 0; i < NB; i++)
      be[i] = i >= int'(a_q[OFF-1:0]) && i < int'(a_q[OFF-1:0]) + (1 << s_q);
  end
  // Read word for the beat entering DATA, with the committing write bypassed in
  always_comb begin
    rd_idx  = accept ? HADDR[OFF +: AW] : a_q[OFF +: AW];
    rd_word = mem[rd_idx];
    for (int i = 0; i < NB; i++)
      if (wr_en && be[i] && a_q[OFF +: AW] == rd_idx) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
  end
  always_comb begin
    nxt     = state == WAIT ? (cnt == '0 ? DATA : WAIT)
            : state == ERR1 ? ERR2
            : accept ? (err ? ERR1 : (wt == '0 ? DATA : WAIT))
            : IDLE;
    cnt_nxt = state == WAIT ? cnt - 1'b1 : accept ? wt - 1'b1 : cnt;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= IDLE;
      cnt    <= '0;
      HRDATA <= '0;
      a_q    <= '0;
      w_q    <= 1'b0;
      s_q    <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        a_q <= HADDR[OFF+AW-1:0];
        w_q <= HWRITE;
        s_q <= HSIZE;
      end
      if (nxt == DATA && !(accept ? HWRITE : w_q)) HRDATA <= rd_word;
    end
  end
  always_ff @(posedge HCLK)
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[a_q[OFF +: AW]][8*i +: 8] <= HWDATA[8*i +: 8];
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed bench for ahb_slave_mem with a zero-wait and a three-wait instance.
module tb_ahb_slave_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel3, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        rdy0, rdy3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rdata0, rdata3;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

  ahb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy3), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] t);
    haddr = a; hwrite = w; hsize = s; htrans = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy0 got %b want 1", rdy0); end
    n_tests++; if (resp0 !== 2'b00) begin n_fail++; $display("FAIL reset_resp0 got %b want 00", resp0); end
    n_tests++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
    n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy3 got %b want 1", rdy3); end
    n_tests++; if (resp3 !== 2'b00) begin n_fail++; $display("FAIL reset_resp3 got %b want 00", resp3); end
    n_tests++; if (rdata3 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3 got %h want 0", rdata3); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    sel0 = 1'b1;
    addr_phase(32'h10, 1'b1, 3'd2, 2'b10);
    step();
    n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL wr_data_phase got rdy=%b resp=%b want 1/00", rdy0, resp0); end
    hwdata = 32'hDEADBEEF;
    addr_phase(32'h10, 1'b0, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL rd_data_phase got rdy=%b resp=%b want 1/00", rdy0, resp0); end
    n_tests++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_bypass got %h want deadbeef", rdata0); end
    step();
    n_tests++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold got %h want deadbeef", rdata0); end
  endtask

  task automatic test_byte_write();
    addr_phase(32'h13, 1'b1, 3'd0, 2'b10);
    step();
    n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL byte_wr_resp got rdy=%b resp=%b want 1/00", rdy0, resp0); end
    hwdata = 32'h5A000000;
    htrans = 2'b00;
    step();
    addr_phase(32'h10, 1'b0, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    n_tests++; if (rdata0 !== 32'h5AADBEEF) begin n_fail++; $display("FAIL byte_lane got %h want 5aadbeef", rdata0); end
  endtask

  task automatic test_unselected();
    sel0 = 1'b0;
    addr_phase(32'h10, 1'b1, 3'd2, 2'b10);
    step();
    hwdata = 32'h0;
    htrans = 2'b00;
    n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL unsel_resp got rdy=%b resp=%b want 1/00", rdy0, resp0); end
    step();
    sel0 = 1'b1;
    addr_phase(32'h10, 1'b0, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    n_tests++; if (rdata0 !== 32'h5AADBEEF) begin n_fail++; $display("FAIL unsel_mem got %h want 5aadbeef", rdata0); end
  endtask

  task automatic test_error();
    addr_phase(32'h0, 1'b1, 3'd2, 2'b10);
    step();
    hwdata = 32'h11223344;
    htrans = 2'b00;
    step();
    addr_phase(32'h400, 1'b1, 3'd2, 2'b10);
    step();
    n_tests++; if (rdy0 !== 1'b0 || resp0 !== 2'b01) begin n_fail++; $display("FAIL range_err1 got rdy=%b resp=%b want 0/01", rdy0, resp0); end
    htrans = 2'b00;
    hwdata = 32'hFFFFFFFF;
    step();
    n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b01) begin n_fail++; $display("FAIL range_err2 got rdy=%b resp=%b want 1/01", rdy0, resp0); end
    step();
    addr_phase(32'h2, 1'b1, 3'd2, 2'b10);
    step();
    n_tests++; if (rdy0 !== 1'b0 || resp0 !== 2'b01) begin n_fail++; $display("FAIL align_err1 got rdy=%b resp=%b want 0/01", rdy0, resp0); end
    htrans = 2'b00;
    step();
    step();
    addr_phase(32'h0, 1'b1, 3'd3, 2'b10);
    step();
    n_tests++; if (rdy0 !== 1'b0 || resp0 !== 2'b01) begin n_fail++; $display("FAIL size_err1 got rdy=%b resp=%b want 0/01", rdy0, resp0); end
    htrans = 2'b00;
    step();
    step();
    n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL err_recover got rdy=%b resp=%b want 1/00", rdy0, resp0); end
    addr_phase(32'h0, 1'b0, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    n_tests++; if (rdata0 !== 32'h11223344) begin n_fail++; $display("FAIL err_mem_kept got %h want 11223344", rdata0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bd [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    hburst = 3'b011;
    for (int i = 0; i < 8; i++) begin
      addr_phase(32'h20 + 32'(4 * (i % 4)), i < 4, 3'd2, (i % 4 == 0) ? 2'b10 : 2'b11);
      hwdata = (i >= 1 && i <= 4) ? bd[i-1] : 32'h0;
      step();
      n_tests++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin n_fail++; $display("FAIL burst_beat%0d got rdy=%b resp=%b want 1/00", i, rdy0, resp0); end
      if (i >= 4) begin
        n_tests++; if (rdata0 !== bd[i-4]) begin n_fail++; $display("FAIL burst_rd%0d got %h want %h", i - 4, rdata0, bd[i-4]); end
      end
    end
    htrans = 2'b00;
    hburst = 3'b000;
    step();
  endtask

  task automatic test_wait_states();
    sel0 = 1'b0;
    sel3 = 1'b1;
    addr_phase(32'h10, 1'b1, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    hwdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) step();
    n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL ws_wr_data got rdy=%b want 1", rdy3); end
    step();
    addr_phase(32'h10, 1'b0, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (rdy3 !== 1'b0 || resp3 !== 2'b00) begin n_fail++; $display("FAIL ws_wait%0d got rdy=%b resp=%b want 0/00", k, rdy3, resp3); end
      step();
    end
    n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL ws_rd_ready got rdy=%b want 1", rdy3); end
    n_tests++; if (rdata3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws_rd_data got %h want cafef00d", rdata3); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    addr_phase(32'h10, 1'b1, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    hwdata = 32'h12345678;
    n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait got rdy=%b want 0", rdy3); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (rdy3 !== 1'b1 || resp3 !== 2'b00) begin n_fail++; $display("FAIL rst_mid_wait got rdy=%b resp=%b want 1/00", rdy3, resp3); end
    addr_phase(32'h10, 1'b0, 3'd2, 2'b10);
    step();
    htrans = 2'b00;
    for (int k = 0; k < 3; k++) step();
    n_tests++; if (rdy3 !== 1'b1 || rdata3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_write_dropped got rdy=%b data=%h want 1/cafef00d", rdy3, rdata3); end
    step();
  endtask

  initial begin
    sel0 = 1'b0; sel3 = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    htrans = 2'b00; hsize = 3'd2; hburst = 3'b000; rst = 1'b1;
    test_reset();
    test_write_read();
    test_byte_write();
    test_unselected();
    test_error();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
